// File: rtl/tdp_ram_pkg.sv
// Shared definitions for the generation-2 true-dual-port RAM:
// clear FSM encoding, read-mode selectors and the byte-lane mask helper.
package tdp_ram_pkg;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    // Widest word / lane count the mask helper supports
    localparam int MASK_W  = 1024;
    localparam int MASK_NB = 128;

    function automatic logic [MASK_W-1:0] lane_mask(
        input logic [MASK_NB-1:0] we,
        input int                 bw,
        input int                 nb
    );
        logic [MASK_W-1:0] m;
        m = '0;
        for (int k = 0; k < MASK_W; k++) begin
            if (k < bw * nb) m[k] = we[k / bw];
        end
        return m;
    endfunction

endpackage

// File: rtl/tdp_ram_gen2_if.sv
// Bus bundle for both RAM ports plus status: the RAM is the slave,
// whoever drives EN/WE/ADDR/D_IN is the master.
interface tdp_ram_if #(
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 3
);
    import tdp_ram_pkg::*;

    localparam int NB = DATA_W / BYTE_W;

    logic              EN_A;
    logic [NB-1:0]     WE_A;
    logic [ADDR_W-1:0] ADDR_A;
    logic [DATA_W-1:0] D_IN_A;
    logic [DATA_W-1:0] Q_OUT_A;
    logic              VALID_A;

    logic              EN_B;
    logic [NB-1:0]     WE_B;
    logic [ADDR_W-1:0] ADDR_B;
    logic [DATA_W-1:0] D_IN_B;
    logic [DATA_W-1:0] Q_OUT_B;
    logic              VALID_B;

    logic              COLLISION;
    logic              INIT_DONE;

    modport master (
        output EN_A, WE_A, ADDR_A, D_IN_A,
        output EN_B, WE_B, ADDR_B, D_IN_B,
        input  Q_OUT_A, VALID_A, Q_OUT_B, VALID_B,
        input  COLLISION, INIT_DONE
    );

    modport slave (
        input  EN_A, WE_A, ADDR_A, D_IN_A,
        input  EN_B, WE_B, ADDR_B, D_IN_B,
        output Q_OUT_A, VALID_A, Q_OUT_B, VALID_B,
        output COLLISION, INIT_DONE
    );

endinterface

// File: rtl/tdp_ram_clr_seq.sv
// Post-reset clear sequencer: walks every address once writing zero,
// then raises init_done and hands the array over to the ports.
module tdp_ram_clr_seq
    import tdp_ram_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_init_done
);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_CLEAR: begin
                    if (CLR_ON_RST == 0 || r_addr == '1) begin
                        r_state <= S_RUN;
                        r_done  <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_addr  <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_we    = (r_state == S_CLEAR) && (CLR_ON_RST != 0);
    assign o_clr_addr  = r_addr;
    assign o_init_done = r_done;

endmodule

// File: rtl/tdp_ram_gen2.sv
// Parametrised true-dual-port RAM with byte enables, read-first/write-first
// modes, optional output register and A-priority same-address collisions.
module tdp_ram_gen2
    import tdp_ram_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BYTE_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int READ_MODE  = 0,
    parameter int OUT_REG    = 0,
    parameter int CLR_ON_RST = 1
) (
    input logic     clk,
    input logic     rst,
    tdp_ram_if.slave bus
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_init_done;

    tdp_ram_clr_seq #(
        .ADDR_W    (ADDR_W),
        .CLR_ON_RST(CLR_ON_RST)
    ) u_clr_seq (
        .clk        (clk),
        .rst        (rst),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_init_done(w_init_done)
    );

    logic              w_acc_a, w_acc_b;
    logic              w_wr_a, w_wr_b;
    logic              w_same;
    logic [DATA_W-1:0] w_mask_a, w_mask_b;
    logic [DATA_W-1:0] w_xmask_a, w_xmask_b;
    logic [DATA_W-1:0] w_old_a, w_old_b;
    logic [DATA_W-1:0] w_new_a, w_new_b;
    logic [DATA_W-1:0] w_rd_a, w_rd_b;

    assign w_acc_a = w_init_done & bus.EN_A;
    assign w_acc_b = w_init_done & bus.EN_B;
    assign w_wr_a  = w_acc_a & (|bus.WE_A);
    assign w_wr_b  = w_acc_b & (|bus.WE_B);
    assign w_same  = (bus.ADDR_A == bus.ADDR_B);

    assign w_mask_a = DATA_W'(lane_mask(MASK_NB'(bus.WE_A), BYTE_W, NB))
                    & {DATA_W{w_acc_a}};
    assign w_mask_b = DATA_W'(lane_mask(MASK_NB'(bus.WE_B), BYTE_W, NB))
                    & {DATA_W{w_acc_b}};

    // Other port's lanes only matter when both hit the same word
    assign w_xmask_a = w_same ? w_mask_a : '0;
    assign w_xmask_b = w_same ? w_mask_b : '0;

    assign w_old_a = r_mem[bus.ADDR_A];
    assign w_old_b = r_mem[bus.ADDR_B];

    // B lanes first, A lanes on top: A wins shared lanes
    assign w_new_a = (((w_old_a & ~w_xmask_b) | (bus.D_IN_B & w_xmask_b))
                     & ~w_mask_a) | (bus.D_IN_A & w_mask_a);
    assign w_new_b = (((w_old_b & ~w_mask_b) | (bus.D_IN_B & w_mask_b))
                     & ~w_xmask_a) | (bus.D_IN_A & w_xmask_a);

    assign w_rd_a = (READ_MODE == WR_FIRST) ? w_new_a : w_old_a;
    assign w_rd_b = (READ_MODE == WR_FIRST) ? w_new_b : w_old_b;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            if (w_wr_a) r_mem[bus.ADDR_A] <= w_new_a;
            if (w_wr_b) r_mem[bus.ADDR_B] <= w_new_b;
        end
    end

    logic [DATA_W-1:0] r_q1_a, r_q1_b;
    logic              r_v1_a, r_v1_b;
    logic              r_coll;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q1_a <= '0;
            r_q1_b <= '0;
            r_v1_a <= 1'b0;
            r_v1_b <= 1'b0;
            r_coll <= 1'b0;
        end else begin
            r_v1_a <= w_acc_a;
            r_v1_b <= w_acc_b;
            if (w_acc_a) r_q1_a <= w_rd_a;
            if (w_acc_b) r_q1_b <= w_rd_b;
            r_coll <= w_acc_a & w_acc_b & w_same
                    & ((|bus.WE_A) | (|bus.WE_B));
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] r_q2_a, r_q2_b;
            logic              r_v2_a, r_v2_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q2_a <= '0;
                    r_q2_b <= '0;
                    r_v2_a <= 1'b0;
                    r_v2_b <= 1'b0;
                end else begin
                    r_v2_a <= r_v1_a;
                    r_v2_b <= r_v1_b;
                    if (r_v1_a) r_q2_a <= r_q1_a;
                    if (r_v1_b) r_q2_b <= r_q1_b;
                end
            end

            assign bus.Q_OUT_A = r_q2_a;
            assign bus.Q_OUT_B = r_q2_b;
            assign bus.VALID_A = r_v2_a;
            assign bus.VALID_B = r_v2_b;
        end else begin : g_noreg
            assign bus.Q_OUT_A = r_q1_a;
            assign bus.Q_OUT_B = r_q1_b;
            assign bus.VALID_A = r_v1_a;
            assign bus.VALID_B = r_v1_b;
        end
    endgenerate

    assign bus.COLLISION = r_coll;
    assign bus.INIT_DONE = w_init_done;

endmodule

// File: tb/tb_tdp_ram_gen2.sv
// Self-checking bench for tdp_ram_gen2: directed scenarios followed by
// random traffic, all compared against a word-array reference model.
module tb_tdp_ram_gen2;

    parameter int READ_MODE = 0;
    parameter int OUT_REG   = 0;

    localparam int DW    = 32;
    localparam int BW    = 8;
    localparam int AW    = 3;
    localparam int NB    = DW / BW;
    localparam int DEPTH = 8;
    localparam int LAT   = (OUT_REG != 0) ? 2 : 1;
    localparam int HMAX  = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tdp_ram_if #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) bus ();

    tdp_ram_gen2 #(
        .DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW),
        .READ_MODE(READ_MODE), .OUT_REG(OUT_REG), .CLR_ON_RST(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] mdl [DEPTH];
    bit            acc_a_h [HMAX];
    bit            acc_b_h [HMAX];
    logic [DW-1:0] rd_a_h  [HMAX];
    logic [DW-1:0] rd_b_h  [HMAX];
    int            n        = 0;
    int            base     = 0;
    int            since_rst = 0;
    int            nchk     = 0;
    int            nerr     = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Last word delivered to a port: most recent accepted read at or
    // before step k since the latest reset, else the reset value.
    function automatic logic [DW-1:0] expq(input bit pb, input int k);
        for (int m = k; m > base; m--) begin
            if (pb ? acc_b_h[m] : acc_a_h[m])
                return pb ? rd_b_h[m] : rd_a_h[m];
        end
        return '0;
    endfunction

    task automatic step(
        input bit ea, input logic [NB-1:0] wa,
        input logic [AW-1:0] aa, input logic [DW-1:0] da,
        input bit eb, input logic [NB-1:0] wb,
        input logic [AW-1:0] ab, input logic [DW-1:0] db
    );
        logic [DW-1:0] nw [DEPTH];
        bit run, col, vexp;
        int k;
        bus.EN_A = ea; bus.WE_A = wa; bus.ADDR_A = aa; bus.D_IN_A = da;
        bus.EN_B = eb; bus.WE_B = wb; bus.ADDR_B = ab; bus.D_IN_B = db;
        run = !rst && (since_rst >= DEPTH);
        n++;
        nw = mdl;
        acc_a_h[n] = run && ea;
        acc_b_h[n] = run && eb;
        if (run) begin
            for (int i = 0; i < NB; i++)
                if (eb && wb[i]) nw[ab][i*BW +: BW] = db[i*BW +: BW];
            for (int i = 0; i < NB; i++)
                if (ea && wa[i]) nw[aa][i*BW +: BW] = da[i*BW +: BW];
        end
        rd_a_h[n] = (READ_MODE != 0) ? nw[aa] : mdl[aa];
        rd_b_h[n] = (READ_MODE != 0) ? nw[ab] : mdl[ab];
        col = run && ea && eb && (aa == ab) && ((wa != 0) || (wb != 0));
        mdl = nw;
        @(posedge clk);
        #1;
        if (rst) begin
            since_rst = 0;
            base = n;
        end else begin
            since_rst++;
            if (since_rst == DEPTH)
                for (int j = 0; j < DEPTH; j++) mdl[j] = '0;
        end
        k = n - LAT + 1;
        chk("init_done", DW'(bus.INIT_DONE),
            DW'(!rst && since_rst >= DEPTH));
        chk("collision", DW'(bus.COLLISION), DW'(col));
        vexp = (k > base) && acc_a_h[k];
        chk("valid_a", DW'(bus.VALID_A), DW'(vexp));
        vexp = (k > base) && acc_b_h[k];
        chk("valid_b", DW'(bus.VALID_B), DW'(vexp));
        chk("q_a", bus.Q_OUT_A, expq(1'b0, k));
        chk("q_b", bus.Q_OUT_B, expq(1'b1, k));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tail();
        for (int i = 1; i < LAT; i++) idle();
    endtask

    task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] we);
        step(1, we, a, d, 0, 0, 0, 0);
    endtask

    task automatic rd_a(input logic [AW-1:0] a);
        step(1, 0, a, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [DW-1:0] cexp;
        for (int j = 0; j < DEPTH; j++) mdl[j] = '0;

        // Reset, then clear must take exactly DEPTH cycles
        rst = 1'b1;
        idle();
        chk("rst_q_a", bus.Q_OUT_A, 32'h0);
        chk("rst_valid_a", DW'(bus.VALID_A), 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            idle();
            chk("init_rise", DW'(bus.INIT_DONE), DW'(i == DEPTH));
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_a(AW'(i));
            tail();
            chk("clear_read", bus.Q_OUT_A, 32'h0);
        end

        // Full-word write then read back
        wr_a(2, 32'hDEADBEEF, 4'hF);
        rd_a(2);
        tail();
        chk("t2_q_a", bus.Q_OUT_A, 32'hDEADBEEF);
        chk("t2_valid_a", DW'(bus.VALID_A), 32'h1);

        // Byte-lane partial write on port B
        wr_a(5, 32'h11223344, 4'hF);
        step(0, 0, 0, 0, 1, 4'b0101, 5, 32'hAABBCCDD);
        step(0, 0, 0, 0, 1, 0, 5, 0);
        tail();
        chk("t3_q_b", bus.Q_OUT_B, 32'h11BB33DD);

        // Same-address collision, A owns its lanes
        step(1, 4'b1100, 3, 32'hFFFF0000, 1, 4'b1111, 3, 32'h12345678);
        chk("t4_coll", DW'(bus.COLLISION), 32'h1);
        tail();
        cexp = (READ_MODE != 0) ? 32'hFFFF5678 : 32'h0;
        chk("t4_q_a", bus.Q_OUT_A, cexp);
        chk("t4_q_b", bus.Q_OUT_B, cexp);
        idle();
        chk("t4_coll_end", DW'(bus.COLLISION), 32'h0);
        step(1, 0, 3, 0, 1, 0, 3, 0);
        tail();
        chk("t4_store_a", bus.Q_OUT_A, 32'hFFFF5678);
        chk("t4_store_b", bus.Q_OUT_B, 32'hFFFF5678);

        // Reset mid-clear, writes during clear must be dropped
        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            step(1, 4'hF, AW'(i + 4), 32'h5A5A5A5A, 1, 4'hF, AW'(i), 32'h3C3C3C3C);
        rst = 1'b1;
        idle();
        chk("t5_rst_init", DW'(bus.INIT_DONE), 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 4'hF, AW'(i - 1), 32'hA5A5A5A5, 1, 4'hF, AW'(8 - i), 32'h96969696);
            chk("t5_init", DW'(bus.INIT_DONE), DW'(i == DEPTH));
            chk("t5_valid_a", DW'(bus.VALID_A), 32'h0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_a(AW'(i));
            tail();
            chk("t5_read", bus.Q_OUT_A, 32'h0);
        end

        // Output hold while the port is idle
        wr_a(6, 32'hCAFEF00D, 4'hF);
        rd_a(6);
        tail();
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t6_hold", bus.Q_OUT_A, 32'hCAFEF00D);
            chk("t6_valid", DW'(bus.VALID_A), 32'h0);
        end

        // Random traffic on a narrow address window to force collisions
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 1) != 0) ? NB'($urandom) : NB'(0),
                 AW'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 1) != 0) ? NB'($urandom) : NB'(0),
                 AW'($urandom_range(0, 3)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
